spi_slave_regfile: RTL and testbench
====================================

Name: spi_slave_regfile

Overview:
- SPI responder (slave) end of the on-chip SPI link: decodes master frames and serves a small register file.
- All SPI pins are oversampled in the system clock domain. SCLK is a sampled signal only and never clocks a flop.
- Used as the far-end target for master-side regression and as the register-access model in SPI/I2C UVM environments.

Parameters:
- NREG, 4, number of 8-bit registers (power of 2, 2..16).
- ADDR_W, 2, address width, equal to log2(NREG).
- SYNC_STAGES, 2, synchronizer depth on SCLK, MOSI and SS.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cpol  input  1  SCLK idle level; static while SS is low.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
- SCLK  input  1  serial clock from master.
- MOSI  input  1  master-to-slave data, MSB first.
- SS  input  1  slave select, active low.
- MISO  output  1  slave-to-master data, MSB first; 0 when not driving.
- reg_out  output  NREG*8  flattened register contents; reg k is at bits [8k+7:8k].
- wr_en  output  1  one-clk pulse on a committed write.
- wr_addr  output  ADDR_W  address of the committed write.
- wr_data  output  8  data of the committed write.
- frame_done  output  1  one-clk pulse when a complete 2-byte frame finishes.

Behaviour:
- Reset values: MISO=0, reg_out=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, FSM=IDLE, bit counter=0, shift registers=0.
- Reset is honoured in any state and aborts a frame in progress without committing a write.
- Synchronization: SCLK, MOSI and SS each pass through SYNC_STAGES flops.
- Edge detection: compare the synced value with its previous sample.
  - Leading edge = SCLK transition away from cpol. Trailing edge = return to cpol.
  - Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other edge.
- Constraint: SCLK high and low phases are each >= 4 clk. SS falling precedes the first SCLK edge by >= 4 clk.
- Frame format:
  - Byte 0 (CMD): bit7 = R/nW (1=read, 0=write); bits[ADDR_W-1:0] = address; other bits ignored.
  - Byte 1 (DATA): write payload, or read response on MISO.
- FSM states:
  - IDLE: MISO=0. On SS falling go to CMD; bit counter=0.
  - CMD: shift MOSI into rx_shift on each sample edge. MISO=0 during CMD. After the 8th sample, latch cmd and go to DATA.
  - DATA (read): on the first shift edge after entering DATA, load tx_shift=reg[addr] and drive MISO=bit7. On each later shift edge, MISO = next bit. After the 8th sample edge, go to DONE.
  - DATA (write): collect 8 MOSI bits. On the 8th sample edge, go to DONE.
  - DONE: for one clk, pulse frame_done. On a write, also pulse wr_en, drive wr_addr/wr_data, and update reg[addr]; reg_out shows the new value on the next clk. Then go to WAIT.
  - WAIT: ignore further SCLK edges; MISO=0. On SS rising go to IDLE.
- Write latency: SS-synced 8th data sample edge to wr_en = 1 clk, i.e. pin edge to wr_en = SYNC_STAGES+2 clk.
- SS rising in CMD or DATA: abort; no write, no frame_done; go to IDLE; MISO=0 on the next clk.
- SS rising and the 8th sample edge detected in the same clk: SS wins (abort).
- SS falling while in WAIT/DONE is impossible without an SS rise in between; SS rise always returns to IDLE first.
- Read of an unpopulated high CMD bit: address uses the low ADDR_W bits only (wrap-around).
- Reads never modify registers.
- A write and a read of the same register in different frames: the read returns the value committed by the earlier frame.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum (IDLE, CMD, DATA, DONE, WAIT).
  - CMD_RW_BIT=7.
  - Localparam BYTE_W=8.
  - Mode encoding constants MODE0..MODE3 = {cpol,cpha}.
- Sub-module spi_edge_sync: synchronizer plus SCLK leading/trailing edge detector plus SS fall/rise detector, outputs sample_pe/shift_pe/ss_fall/ss_rise.

Test Plan:
- Mode 0, write frame CMD=0x01, DATA=0xA5 -> wr_en pulse once, wr_addr=1, wr_data=0xA5, reg_out[15:8]=0xA5, frame_done pulse once.
- Mode 3, write reg2=0x3C, then read CMD=0x82 -> MISO sequence during byte1 = 0,0,1,1,1,1,0,0; reg_out unchanged.
- All four modes: write reg3=0x96, read back -> master rx_data=0x96 in each mode.
- SS raised after 5 data bits of write to reg0 -> no wr_en, no frame_done, reg0 stays 0x00, MISO=0.
- 3-byte frame (write reg1=0x11, extra byte 0xFF) -> single write of 0x11, third byte ignored, returns to IDLE on SS high.
- reset asserted mid-CMD, then released -> all outputs 0; next full frame write reg0=0x5A succeeds.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder register file.
package spi_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DONE,
    WAIT
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Oversamples SCLK/MOSI/SS into clk, then emits registered one-clk event
// pulses for the sample/shift SCLK edges and SS fall/rise.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cpol,
  input  logic cpha,
  input  logic sclk,
  input  logic mosi,
  input  logic ss,
  output logic mosi_s,
  output logic sample_pe,
  output logic shift_pe,
  output logic ss_fall,
  output logic ss_rise
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_prev, ss_prev;
  logic sclk_now, ss_now;
  logic lead, trail;

  assign sclk_now = sclk_sync[SYNC_STAGES-1];
  assign ss_now   = ss_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead  = (sclk_now != sclk_prev) && (sclk_prev == cpol);
  assign trail = (sclk_now != sclk_prev) && (sclk_now == cpol);

  // SS chain resets to deselected so release of reset never looks like a select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
      mosi_s    <= 1'b0;
      sample_pe <= 1'b0;
      shift_pe  <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_prev <= sclk_now;
      ss_prev   <= ss_now;
      mosi_s    <= mosi_sync[SYNC_STAGES-1];
      sample_pe <= cpha ? trail : lead;
      shift_pe  <= cpha ? lead : trail;
      ss_fall   <= ss_prev & ~ss_now;
      ss_rise   <= ~ss_prev & ss_now;
    end
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI responder serving a small 8-bit register file; 2-byte frames of
// {R/nW, addr} followed by write data or read response.
//
// state | meaning
// IDLE  | deselected, waiting for SS fall
// CMD   | shifting in the command byte
// DATA  | write: collecting payload; read: driving register on MISO
// DONE  | one clk: frame_done, and commit on a write
// WAIT  | frame finished, ignore SCLK until SS rises
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int NREG        = 4,
  parameter int ADDR_W      = $clog2(NREG),
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  output logic [NREG*8-1:0]     reg_out,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [BYTE_W-1:0]     wr_data,
  output logic                  frame_done
);

  state_t              state, state_nxt;
  logic                mosi_s, sample_pe, shift_pe, ss_fall, ss_rise;
  logic [2:0]          bit_cnt;
  logic [BYTE_W-1:0]   rx_shift, tx_shift, rx_next;
  logic                cmd_rw;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                tx_loaded;
  logic                last_bit;
  logic [BYTE_W-1:0]   regs [NREG];

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .cpol      (cpol),
    .cpha      (cpha),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .ss        (SS),
    .mosi_s    (mosi_s),
    .sample_pe (sample_pe),
    .shift_pe  (shift_pe),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  assign rx_next  = {rx_shift[BYTE_W-2:0], mosi_s};
  assign last_bit = sample_pe && (bit_cnt == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // SS rise takes priority over a coincident 8th sample edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ss_fall) state_nxt = CMD;
      CMD: begin
        if (ss_rise)       state_nxt = IDLE;
        else if (last_bit) state_nxt = DATA;
      end
      DATA: begin
        if (ss_rise)       state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      DONE:    state_nxt = ss_rise ? IDLE : WAIT;
      WAIT:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt counts down the remaining sample edges of the current byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      tx_loaded <= 1'b0;
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      case (state)
        IDLE: if (ss_fall) begin
          bit_cnt   <= 3'd7;
          rx_shift  <= '0;
          tx_loaded <= 1'b0;
        end
        CMD: if (sample_pe) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            cmd_rw   <= rx_next[CMD_RW_BIT];
            cmd_addr <= rx_next[ADDR_W-1:0];
            bit_cnt  <= 3'd7;
          end
        end
        DATA: begin
          if (sample_pe) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt - 3'd1;
          end
          if (shift_pe && cmd_rw) begin
            if (!tx_loaded) begin
              tx_shift  <= regs[cmd_addr];
              tx_loaded <= 1'b1;
            end else begin
              tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            end
          end
        end
        DONE: if (!cmd_rw) regs[cmd_addr] <= rx_shift;
        default: ;
      endcase
    end
  end

  always_comb begin
    MISO = 1'b0;
    if (state == DATA && cmd_rw && tx_loaded) MISO = tx_shift[BYTE_W-1];
  end

  assign wr_en      = (state == DONE) && !cmd_rw;
  assign frame_done = (state == DONE);
  assign wr_addr    = cmd_addr;
  assign wr_data    = rx_shift;

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NREG; k++) reg_out[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: a bit-banged SPI master plus a
// register-file model checked against the DUT on every clk.
module tb_spi_slave_regfile;
  import spi_pkg::*;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpol = 1'b0, cpha = 1'b0, SCLK = 1'b0, MOSI = 1'b0, SS = 1'b1;
  logic        MISO, wr_en, frame_done;
  logic [31:0] reg_out;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;

  spi_slave_regfile #(.NREG(4), .ADDR_W(2), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpol       (cpol),
    .cpha       (cpha),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .SS         (SS),
    .MISO       (MISO),
    .reg_out    (reg_out),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;

  int         n_checks = 0, n_fail = 0;
  int         fd_seen = 0, fd_exp = 0, ss_hi_cnt = 0;
  logic [7:0] model_regs [4];
  wr_t        wq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] f;
    for (int k = 0; k < 4; k++) f[8*k +: 8] = model_regs[k];
    return f;
  endfunction

  // Model: registers change only by committed writes, visible the clk after wr_en.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) model_regs[k] = 8'h00;
      wq.delete();
      fd_seen   = 0;
      ss_hi_cnt = 0;
    end else begin
      check("reg_out", reg_out, model_flat());
      if (wr_en) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got wr_en=1 addr=%0h data=%0h expected no write", wr_addr, wr_data);
        end else begin
          check("wr_addr", {30'd0, wr_addr}, {30'd0, wq[0].a});
          check("wr_data", {24'd0, wr_data}, {24'd0, wq[0].d});
          model_regs[wq[0].a] = wq[0].d;
          void'(wq.pop_front());
        end
      end
      if (frame_done) fd_seen++;
      ss_hi_cnt = SS ? ss_hi_cnt + 1 : 0;
      if (ss_hi_cnt > 6) check("miso_idle", {31'd0, MISO}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Master frame of nbits bits from tx (MSB first); rx collects MISO per bit.
  task automatic xfer(input logic [1:0] mode, input logic [23:0] tx, input int nbits,
                      output logic [23:0] rx);
    cpol = mode[1];
    cpha = mode[0];
    SCLK = mode[1];
    tick(8);
    if (nbits >= 16) begin
      fd_exp++;
      if (!tx[23]) wq.push_back('{tx[17:16], tx[15:8]});
    end
    rx = '0;
    SS = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        MOSI = tx[23-i];
        tick(H);
        rx[23-i] = MISO;
        SCLK = ~cpol;
        tick(H);
        SCLK = cpol;
      end else begin
        SCLK = ~cpol;
        MOSI = tx[23-i];
        tick(H);
        rx[23-i] = MISO;
        SCLK = cpol;
        tick(H);
      end
    end
    tick(H);
    SS   = 1'b1;
    MOSI = 1'b0;
    tick(12);
  endtask

  task automatic frame_checks(input string tag);
    check({tag, "_frame_done_cnt"}, fd_seen, fd_exp);
    check({tag, "_wr_pending"}, wq.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_miso"}, {31'd0, MISO}, 32'd0);
    check({tag, "_reg_out"}, reg_out, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {30'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] rx;
    logic [1:0]  m;

    tick(5);
    reset = 1'b0;
    tick(2);
    check_outputs_zero("reset");

    // Mode 0 write reg1 = A5
    xfer(MODE0, 24'h01A500, 16, rx);
    frame_checks("m0_wr");
    check("m0_reg1", {24'd0, reg_out[15:8]}, 32'hA5);

    // Mode 3 write reg2 = 3C then read it back
    xfer(MODE3, 24'h023C00, 16, rx);
    frame_checks("m3_wr");
    xfer(MODE3, 24'h820000, 16, rx);
    frame_checks("m3_rd");
    check("m3_rd_data", {24'd0, rx[15:8]}, 32'h3C);
    check("m3_rd_cmd_miso", {24'd0, rx[23:16]}, 32'h00);
    check("m3_reg_unchanged", reg_out, 32'h003CA500);

    // All four modes: write reg3 = 96, read back
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      xfer(m, 24'h039600, 16, rx);
      frame_checks("modes_wr");
      xfer(m, 24'h830000, 16, rx);
      frame_checks("modes_rd");
      check("modes_rd_data", {24'd0, rx[15:8]}, {24'd0, model_regs[3]});
      check("modes_rd_lit", {24'd0, rx[15:8]}, 32'h96);
    end

    // Abort after CMD + 5 data bits of a write to reg0
    xfer(MODE0, 24'h007700, 13, rx);
    frame_checks("abort");
    check("abort_reg0", {24'd0, reg_out[7:0]}, 32'h00);
    check("abort_miso", {31'd0, MISO}, 32'd0);

    // 3-byte frame: only the first data byte commits
    xfer(MODE0, 24'h0111FF, 24, rx);
    frame_checks("three_byte");
    check("three_byte_reg1", {24'd0, reg_out[15:8]}, 32'h11);

    // Read with high unused CMD bits set: 0x8D decodes to reg1
    xfer(MODE1, 24'h8D0000, 16, rx);
    frame_checks("wrap_rd");
    check("wrap_rd_data", {24'd0, rx[15:8]}, 32'h11);

    // Reset mid-CMD, then a clean write of reg0 = 5A
    cpol = 1'b0;
    cpha = 1'b0;
    SCLK = 1'b0;
    tick(8);
    SS = 1'b0;
    tick(H);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      tick(H);
      SCLK = 1'b1;
      tick(H);
      SCLK = 1'b0;
    end
    reset  = 1'b1;
    fd_exp = 0;
    SS     = 1'b1;
    MOSI   = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    check_outputs_zero("mid_reset");
    xfer(MODE0, 24'h005A00, 16, rx);
    frame_checks("post_reset");
    check("post_reset_reg0", {24'd0, reg_out[7:0]}, 32'h5A);
    check("post_reset_regs", reg_out, 32'h0000005A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
